seq_bit_reverser: RTL and testbench
===================================

Name: seq_bit_reverser

Overview:
- Multi-cycle, handshaked bit-reversal engine.
- Sequential counterpart to the team's combinational `reverse` function: the caller hands in a word, and the block returns it with bit k moved to bit MAX-1-k.
- Reverses through shift registers, one bit per cycle, so it can sit between valid/ready-connected producer and consumer blocks.

Parameters:
- MAX, 8: data width in bits; legal range MAX >= 2. Counter width is derived internally as $clog2(MAX).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer asserts when din is valid.
- in_ready  output  1  block can accept a word.
- din  input  MAX  word to reverse.
- out_valid  output  1  dout holds the reversed word.
- out_ready  input  1  consumer accepts dout.
- dout  output  MAX  reversed word.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). Sampled only on the rising clk edge.
- Reset values: state=IDLE, out_valid=0, dout=0, busy=0, internal src/acc/cnt=0. in_ready is 0 while reset is high and 1 in the first cycle after reset drops.
- Outputs: in_ready = (state==IDLE) && !reset. busy = (state!=IDLE). out_valid = (state==DONE), registered.
- FSM, three states:
  - IDLE: when in_valid && in_ready, load src<=din, acc<=0, cnt<=0, go to SHIFT. Otherwise stay.
  - SHIFT: every cycle acc<={acc[MAX-2:0], src[0]}, src<=src>>1, cnt<=cnt+1. On the edge where cnt==MAX-1: dout<={acc[MAX-2:0], src[0]}, out_valid<=1, go to DONE.
  - DONE: hold dout and out_valid stable. On out_valid && out_ready, clear out_valid and go to IDLE.
- Latency: out_valid rises exactly MAX clk edges after the accept edge.
- Throughput: one word per MAX+2 cycles minimum.
- No overlap: in_ready=0 in SHIFT and DONE. in_valid during those states is ignored and must not corrupt src.
- dout after delivery: keeps the last delivered value until the next DONE entry. It is not cleared on load.
- Simultaneous events: reset has priority over every handshake and shift. in_valid and out_ready both high in DONE gives only the output handshake; the new word is accepted no earlier than the next cycle, in IDLE.
- Reset mid-operation, in SHIFT or DONE: the word is dropped. Next state is IDLE with dout=0 and out_valid=0. No partial result is ever presented.
- Producer side: din may change freely once the accept edge has passed.
- Width: all shifts are MAX bits wide, with no sign extension. cnt wraps only via the load to 0.

Optional Feature:
- Macro: SEQ_BIT_REVERSER_SHIFT2_EN.
- When defined:
  - Two bits are processed per cycle: acc<={acc[MAX-3:0], src[0], src[1]}, src<=src>>2.
  - Terminal count is MAX/2-1, so latency is MAX/2 edges.
  - MAX must be even; an odd MAX triggers an elaboration-time $error.
- When undefined: one bit per cycle as specified above, latency MAX. All other behaviour, ports and reset values are identical in both builds.

Test Plan:
1. MAX=8, reset 2 cycles, din=8'h01 with in_valid for 1 cycle, out_ready=1 -> out_valid rises 8 edges after accept, dout=8'h80, out_valid high exactly 1 cycle. Then 8'hF0 -> 8'h0F, and 8'hA5 -> 8'hA5.
2. Backpressure: din=8'h3C, out_ready=0 for 5 cycles after DONE -> out_valid=1 and dout=8'h3C stable all 5 cycles, in_ready=0. A stray in_valid with din=8'hFF has no effect. Then out_ready=1 -> IDLE next cycle.
3. Reset during SHIFT, 3 edges after accepting 8'h0F -> next cycle state IDLE, out_valid=0, dout=8'h00, busy=0. No out_valid pulse follows.
4. Back-to-back: 8'h01 then 8'h03, in_valid held high, out_ready=1 -> outputs 8'h80 then 8'hC0. The second word is accepted the cycle after the first output handshake. Accept-to-accept spacing is 10 cycles.
5. Reset asserted in DONE while out_ready=1 -> no handshake counted, dout=0, in_ready=0 during reset and 1 after.
6. With SEQ_BIT_REVERSER_SHIFT2_EN: MAX=8, din=8'h01 -> dout=8'h80 after 4 edges. MAX=16, din=16'h0001 -> dout=16'h8000 after 8 edges.

Source files
------------

// File: rtl/seq_bit_reverser.sv
// seq_bit_reverser
//   Multi-cycle, valid/ready handshaked bit reversal. An accepted word is
//   shifted out of a source register into an accumulator, so that bit k of
//   din ends up at bit MAX-1-k of dout.
//
//   Optional build macro: SEQ_BIT_REVERSER_SHIFT2_EN
//     defined   -> two bits per cycle, latency MAX/2 (MAX must be even)
//     undefined -> one bit per cycle, latency MAX
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-high reset
//     in_valid   producer has a word on din
//     in_ready   block can accept a word (IDLE and not in reset)
//     din        word to reverse (MAX bits)
//     out_valid  dout holds a reversed word (registered)
//     out_ready  consumer accepts dout
//     dout       reversed word, held until the next result replaces it
//     busy       a word is in flight (SHIFT or DONE)
//
//   state  | meaning
//   IDLE   | waiting for in_valid, in_ready high
//   SHIFT  | moving bits from src into acc
//   DONE   | result presented on dout, waiting for out_ready
module seq_bit_reverser #(
  parameter int MAX = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MAX-1:0] din,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MAX-1:0] dout,
  output logic           busy
);

  localparam int CW = $clog2(MAX);

`ifdef SEQ_BIT_REVERSER_SHIFT2_EN
  localparam int LAST = MAX / 2 - 1;
  if ((MAX % 2) != 0) begin : g_odd_max
    $error("seq_bit_reverser: MAX must be even when two bits are shifted per cycle");
  end
`else
  localparam int LAST = MAX - 1;
`endif

  if (MAX < 2) begin : g_small_max
    $error("seq_bit_reverser: MAX must be at least 2");
  end

  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [MAX-1:0] src_q, src_d;
  logic [MAX-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [MAX-1:0] dout_q, dout_d;
  logic           out_valid_q, out_valid_d;

  logic [MAX-1:0] acc_shift;
  logic [MAX-1:0] src_shift;

`ifdef SEQ_BIT_REVERSER_SHIFT2_EN
  // Built as a MAX-wide OR so the expression stays legal down to MAX=2.
  logic [MAX-1:0] pair;
  always_comb begin
    pair      = '0;
    pair[1:0] = {src_q[0], src_q[1]};
    acc_shift = (acc_q << 2) | pair;
    src_shift = src_q >> 2;
  end
`else
  always_comb begin
    acc_shift = {acc_q[MAX-2:0], src_q[0]};
    src_shift = src_q >> 1;
  end
`endif

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign dout      = dout_q;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          src_d   = din;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = acc_shift;
        src_d = src_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          dout_d      = acc_shift;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // Reset also drops any word in flight, including a result sitting in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_seq_bit_reverser.sv
module tb_seq_bit_reverser;

  localparam int MAX = 8;
`ifdef SEQ_BIT_REVERSER_SHIFT2_EN
  localparam int LAT = MAX / 2;
`else
  localparam int LAT = MAX;
`endif

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [MAX-1:0] din;
  logic           out_valid;
  logic           out_ready;
  logic [MAX-1:0] dout;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_bit_reverser #(.MAX(MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [MAX-1:0] din;
    logic [MAX-1:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready, offers the word for one accept edge, then
  // either drops in_valid or keeps a stray in_valid with din=FF.
  task automatic accept_word(input logic [MAX-1:0] d, input bit stray);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    din      = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = stray;
    din      = stray ? '1 : MAX'($urandom);
  endtask

  // Counts edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  vec_t vecs[8];
  int   lat;

  initial begin
    vecs[0] = '{8'h01, 8'h80};
    vecs[1] = '{8'hF0, 8'h0F};
    vecs[2] = '{8'hA5, 8'hA5};
    vecs[3] = '{8'h12, 8'h48};
    vecs[4] = '{8'h80, 8'h01};
    vecs[5] = '{8'hFF, 8'hFF};
    vecs[6] = '{8'h00, 8'h00};
    vecs[7] = '{8'h6B, 8'hD6};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din       = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // table-driven words, consumer always ready
    for (int i = 0; i < 8; i++) begin
      accept_word(vecs[i].din, 1'b0);
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_dout", i), {24'd0, dout}, {24'd0, vecs[i].exp});
      check($sformatf("vec%0d_in_ready_done", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("vec%0d_busy_done", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("vec%0d_idle_ready", i), {31'd0, in_ready}, 32'd1);
      check($sformatf("vec%0d_dout_hold", i), {24'd0, dout}, {24'd0, vecs[i].exp});
    end

    // backpressure with stray in_valid during SHIFT and DONE
    out_ready = 1'b0;
    accept_word(8'h3C, 1'b1);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    check("bp_dout", {24'd0, dout}, 32'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d_dout", i), {24'd0, dout}, 32'h3C);
      check($sformatf("bp%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_busy", {31'd0, busy}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

    // reset 3 edges into SHIFT
    accept_word(8'h0F, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("shift_dout_not_cleared", {24'd0, dout}, 32'h3C);
    check("shift_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rs_out_valid", {31'd0, out_valid}, 32'd0);
    check("rs_dout", {24'd0, dout}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid) pulses++;
      end
      check("rs_no_pulse", 32'(pulses), 32'd0);
    end
    check("rs_in_ready_after", {31'd0, in_ready}, 32'd1);

    // back-to-back with in_valid held high
    begin
      int             acc2_edge;
      int             nout;
      logic [MAX-1:0] outs[2];
      acc2_edge = -1;
      nout      = 0;
      outs[0]   = '0;
      outs[1]   = '0;
      @(negedge clk);
      in_valid = 1'b1;
      din      = 8'h01;
      @(posedge clk);
      @(negedge clk);
      din = 8'h03;
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        if (out_valid) begin
          outs[nout] = dout;
          nout++;
          if (nout == 2) break;
        end
        if (acc2_edge < 0 && in_valid && in_ready) acc2_edge = c + 1;
        else if (acc2_edge >= 0) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      check("b2b_outputs", 32'(nout), 32'd2);
      check("b2b_first", {24'd0, outs[0]}, 32'h80);
      check("b2b_second", {24'd0, outs[1]}, 32'hC0);
      check("b2b_spacing", 32'(acc2_edge), 32'(LAT + 2));
    end
    @(negedge clk);

    // reset in DONE with out_ready high
    accept_word(8'hA5, 1'b0);
    wait_out(lat);
    check("rd_latency", 32'(lat), 32'(LAT));
    reset = 1'b1;
    @(negedge clk);
    check("rd_out_valid", {31'd0, out_valid}, 32'd0);
    check("rd_dout", {24'd0, dout}, 32'd0);
    check("rd_in_ready", {31'd0, in_ready}, 32'd0);
    check("rd_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rd_in_ready_after", {31'd0, in_ready}, 32'd1);
    check("rd_out_valid_after", {31'd0, out_valid}, 32'd0);
    accept_word(8'h12, 1'b0);
    wait_out(lat);
    check("rd_recover_latency", 32'(lat), 32'(LAT));
    check("rd_recover_dout", {24'd0, dout}, 32'h48);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
